// File: rtl/rf_wr_sched_if.sv
// rf_wr_sched_if: bundle of the WB / MCU / decode / RF-port signals around the
// register-file write scheduler.
//   master : the surrounding pipeline (drives requests, sees port and stalls)
//   slave  : the scheduler itself
// Signals:
//   wb_we, wb_wR, wb_wD          in-order writeback request
//   mc_valid, mc_ready, mc_wR,
//   mc_wD                        multi-cycle unit result handshake
//   iss_valid, iss_rd            MCU op issue (marks destination busy)
//   q_rs1, q_rs2, q_rd           decode-stage operands to check
//   hz_stall, wb_stall           stall requests toward decode / pipeline
//   rf_we, rf_wR, rf_wD          register-file write port
interface rf_wr_sched_if;
  logic        wb_we;
  logic [4:0]  wb_wR;
  logic [31:0] wb_wD;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_wR;
  logic [31:0] mc_wD;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        hz_stall;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;

  modport master (
    output wb_we, wb_wR, wb_wD, mc_valid, mc_wR, mc_wD, iss_valid, iss_rd,
           q_rs1, q_rs2, q_rd,
    input  mc_ready, hz_stall, wb_stall, rf_we, rf_wR, rf_wD
  );

  modport slave (
    input  wb_we, wb_wR, wb_wD, mc_valid, mc_wR, mc_wD, iss_valid, iss_rd,
           q_rs1, q_rs2, q_rd,
    output mc_ready, hz_stall, wb_stall, rf_we, rf_wR, rf_wD
  );
endinterface

// File: rtl/rf_wr_sched.sv
// rf_wr_sched: write-port scheduler and scoreboard for the 32x32 register file.
// WB writeback has fixed priority on the single RF write port; multi-cycle unit
// results are buffered in a DEPTH-entry FIFO and drained whenever WB is idle.
// A busy bit per register tracks outstanding MCU results and drives hz_stall.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          rf_wr_sched_if.slave (WB, MCU handshake, issue, decode query,
//                stall outputs, RF write port)
// Parameters:
//   DEPTH        FIFO entries, power of two in 2..16
//   STARVE_LIM   full-FIFO starvation cycles before a fairness stall
// Build option:
//   RF_WR_FAIR_EN  enables the starvation counter and registered wb_stall;
//                  without it wb_stall is tied 0.
module rf_wr_sched #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input logic          clk,
  input logic          rst_n,
  rf_wr_sched_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rf_wr_sched: DEPTH must be a power of two in 2..16");
  end
  if (STARVE_LIM == 0) begin : g_bad_lim
    $error("rf_wr_sched: STARVE_LIM must be non-zero");
  end

  logic [4:0]    mem_wr_q [DEPTH];
  logic [31:0]   mem_wd_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;

  logic        wb_act;
  logic        push;
  logic        pop;
  logic [4:0]  head_wr;
  logic [31:0] head_wd;

  assign wb_act  = bus.wb_we && (bus.wb_wR != 5'd0);
  assign head_wr = mem_wr_q[rd_ptr_q];
  assign head_wd = mem_wd_q[rd_ptr_q];

  assign bus.mc_ready = (count_q < CW'(DEPTH));
  assign push         = bus.mc_valid && bus.mc_ready;
  // FIFO only drains on cycles WB leaves the port free.
  assign pop          = !wb_act && (count_q != '0);

  // RF port mux; a popped x0 entry is consumed without a write.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wR = 5'd0;
    bus.rf_wD = 32'd0;
    if (wb_act) begin
      bus.rf_we = 1'b1;
      bus.rf_wR = bus.wb_wR;
      bus.rf_wD = bus.wb_wD;
    end else if (pop && head_wr != 5'd0) begin
      bus.rf_we = 1'b1;
      bus.rf_wR = head_wr;
      bus.rf_wD = head_wd;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear on pop first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop && head_wr != 5'd0) begin
      busy_d[head_wr] = 1'b0;
    end
    if (bus.iss_valid && bus.iss_rd != 5'd0) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign bus.hz_stall = busy_q[bus.q_rs1] | busy_q[bus.q_rs2] | busy_q[bus.q_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Payload storage needs no reset: entries are only read behind count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wr_q[wr_ptr_q] <= bus.mc_wR;
      mem_wd_q[wr_ptr_q] <= bus.mc_wD;
    end
  end

`ifdef RF_WR_FAIR_EN
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          wb_stall_q, wb_stall_d;

  always_comb begin
    starve_d   = '0;
    wb_stall_d = 1'b0;
    if ((count_q == CW'(DEPTH)) && wb_act) begin
      starve_d = starve_q + SW'(1);
    end
    if (starve_d == SW'(STARVE_LIM)) begin
      wb_stall_d = 1'b1;
      starve_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  assign bus.wb_stall = wb_stall_q;
`else
  assign bus.wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_sched.sv
// Bench for rf_wr_sched: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_rf_wr_sched;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_LIM = 8;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  rf_wr_sched_if bus ();

  rf_wr_sched #(
    .DEPTH      (DEPTH),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state.
  ent_t        mq[$];
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_stall;
  bit          mc_acc;
  int          stall_seen;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already applied (posedge+1). Check at negedge,
  // advance the model at the posedge, return at posedge+1.
  task automatic step();
    bit          wb_act, pop, push, full, exp_ready, exp_we;
    logic [4:0]  hw, exp_wr;
    logic [31:0] hd;
    if (m_stall) bus.wb_we = 1'b0;  // pipeline honours the fairness stall
    @(negedge clk);
    wb_act    = bus.wb_we && bus.wb_wR != 5'd0;
    pop       = !wb_act && mq.size() > 0;
    hw        = pop ? mq[0].wr : 5'd0;
    hd        = pop ? mq[0].wd : 32'd0;
    full      = mq.size() == DEPTH;
    exp_ready = !full;
    exp_we    = wb_act || (pop && hw != 5'd0);
    exp_wr    = wb_act ? bus.wb_wR : hw;
    check_eq("mc_ready", bus.mc_ready, exp_ready);
    check_eq("rf_we", bus.rf_we, exp_we);
    check_eq("rf_wR", bus.rf_wR, exp_wr);
    if (exp_we) check_eq("rf_wD", bus.rf_wD, wb_act ? bus.wb_wD : hd);
    check_eq("hz_stall", bus.hz_stall,
             m_busy[bus.q_rs1] | m_busy[bus.q_rs2] | m_busy[bus.q_rd]);
    check_eq("wb_stall", bus.wb_stall, m_stall);
    if (bus.wb_stall) stall_seen++;
    push   = bus.mc_valid && exp_ready;
    mc_acc = push;
    @(posedge clk);
    if (full && wb_act) m_starve++;
    else m_starve = 0;
    m_stall = 1'b0;
`ifdef RF_WR_FAIR_EN
    if (m_starve == STARVE_LIM) begin
      m_stall  = 1'b1;
      m_starve = 0;
    end
`endif
    if (pop) begin
      m_busy[hw] = 1'b0;
      void'(mq.pop_front());
    end
    if (push) mq.push_back('{wr: bus.mc_wR, wd: bus.mc_wD});
    if (bus.iss_valid) m_busy[bus.iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    bus.wb_we     = 1'b0;
    bus.mc_valid  = 1'b0;
    bus.iss_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mc_ready", bus.mc_ready, 1'b1);
    check_eq("rst_hz_stall", bus.hz_stall, 1'b0);
    check_eq("rst_wb_stall", bus.wb_stall, 1'b0);
    check_eq("rst_rf_we", bus.rf_we, 1'b0);
    check_eq("rst_rf_wR", bus.rf_wR, 5'd0);
    check_eq("rst_rf_wD", bus.rf_wD, 32'd0);
    mq.delete();
    m_busy   = '0;
    m_starve = 0;
    m_stall  = 1'b0;
    mc_acc   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; stall_seen = 0;
    bus.wb_we = 0; bus.wb_wR = 0; bus.wb_wD = 0;
    bus.mc_valid = 0; bus.mc_wR = 0; bus.mc_wD = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
    bus.q_rs1 = 0; bus.q_rs2 = 0; bus.q_rd = 0;
    #1;
    do_reset();

    // Issue rd=5, MCU result, write one cycle after accept, hazard clears.
    bus.iss_valid = 1; bus.iss_rd = 5;
    step();
    bus.iss_valid = 0;
    bus.mc_valid = 1; bus.mc_wR = 5; bus.mc_wD = 32'hDEAD_BEEF; bus.q_rs1 = 5;
    #1 check_eq("t1_hz_busy", bus.hz_stall, 1'b1);
    check_eq("t1_no_cut_through", bus.rf_we, 1'b0);
    step();
    bus.mc_valid = 0;
    #1 check_eq("t1_we", bus.rf_we, 1'b1);
    check_eq("t1_wR", bus.rf_wR, 5'd5);
    check_eq("t1_wD", bus.rf_wD, 32'hDEAD_BEEF);
    step();
    #1 check_eq("t1_hz_clear", bus.hz_stall, 1'b0);
    step();

    // WB every cycle while 4 results fill the FIFO, then starvation window.
    bus.wb_we = 1; bus.wb_wR = 3;
    for (int i = 0; i < 4; i++) begin
      bus.wb_wD = 32'h100 + i;
      bus.mc_valid = 1; bus.mc_wR = 5'(8 + i); bus.mc_wD = 32'hA000 + i;
      step();
    end
    bus.mc_valid = 0;
    #1 check_eq("t2_full_ready", bus.mc_ready, 1'b0);
    stall_seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus.wb_we = 1; bus.wb_wD = 32'h200 + i;
      step();
    end
`ifdef RF_WR_FAIR_EN
    check_eq("t6_stall_count", stall_seen, 1);
`else
    check_eq("t6_stall_count", stall_seen, 0);
`endif
    bus.wb_we = 0;
    for (int i = 0; i < 5; i++) step();

    // Same-cycle set and clear of busy[7]: set wins.
    bus.iss_valid = 1; bus.iss_rd = 7;
    step();
    bus.iss_valid = 0; bus.mc_valid = 1; bus.mc_wR = 7; bus.mc_wD = 32'h77;
    step();
    bus.mc_valid = 0; bus.iss_valid = 1; bus.iss_rd = 7;
    step();
    bus.iss_valid = 0; bus.q_rs1 = 7;
    #1 check_eq("t3_busy7_kept", bus.hz_stall, 1'b1);
    step();

    // x0: MCU entry and WB write both produce no RF write; x0 never busy.
    bus.q_rs1 = 0; bus.q_rs2 = 0; bus.q_rd = 0;
    bus.iss_valid = 1; bus.iss_rd = 0;
    bus.mc_valid = 1; bus.mc_wR = 0; bus.mc_wD = 32'h55;
    bus.wb_we = 1; bus.wb_wR = 0; bus.wb_wD = 32'h66;
    step();
    bus.iss_valid = 0; bus.mc_valid = 0;
    #1 check_eq("t4_x0_pop_we", bus.rf_we, 1'b0);
    check_eq("t4_x0_hz", bus.hz_stall, 1'b0);
    step();
    bus.wb_we = 0;
    step();

    // Mid-operation reset with three entries buffered and busy bits set.
    bus.wb_we = 1; bus.wb_wR = 2;
    for (int i = 0; i < 3; i++) begin
      bus.iss_valid = 1; bus.iss_rd = 5'(12 + i);
      bus.mc_valid = 1; bus.mc_wR = 5'(12 + i); bus.mc_wD = 32'hC0 + i;
      step();
    end
    bus.iss_valid = 0; bus.mc_valid = 0;
    bus.q_rs1 = 12; bus.q_rs2 = 13; bus.q_rd = 14;
    #1 check_eq("t5_pre_hz", bus.hz_stall, 1'b1);
    do_reset();
    step();

    // Randomized traffic with phases of heavy and light WB load.
    for (int i = 0; i < 800; i++) begin
      bus.wb_we = ((i / 100) % 2 == 1) ? ($urandom_range(0, 9) != 0)
                                       : ($urandom_range(0, 9) < 3);
      bus.wb_wR = 5'($urandom_range(0, 7));
      bus.wb_wD = $urandom;
      if (!bus.mc_valid || mc_acc) begin
        bus.mc_valid = 1'($urandom_range(0, 1));
        bus.mc_wR    = 5'($urandom_range(0, 7));
        bus.mc_wD    = $urandom;
      end
      bus.iss_valid = ($urandom_range(0, 3) == 0);
      bus.iss_rd    = 5'($urandom_range(0, 7));
      bus.q_rs1     = 5'($urandom_range(0, 7));
      bus.q_rs2     = 5'($urandom_range(0, 7));
      bus.q_rd      = 5'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wr_sched.md
# rf_wr_sched

Write-port scheduler and scoreboard for the 32×32 register file. Merges two write sources onto the single RF write port: the in-order pipeline writeback (WB, fixed priority, never backpressured) and a multi-cycle unit (MCU: divider/load unit) that delivers results out of band through a valid/ready handshake into a small FIFO. Tracks destination registers with an MCU result outstanding and raises a hazard stall toward the decode stage. Sits between WB/MCU and the RF; drives the RF write enable, address and data.

## Interface
- `DEPTH`, 4: MCU result FIFO entries; power of two, 2..16.
- `STARVE_LIM`, 8: cycles of full-FIFO starvation before the fairness stall fires (used only with `RF_WR_FAIR_EN`).
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_we` in 1: WB write request.
- `wb_wR` in 5: WB destination register.
- `wb_wD` in 32: WB write data.
- `mc_valid` in 1: MCU result valid.
- `mc_ready` out 1: FIFO can accept (`count < DEPTH`).
- `mc_wR` in 5: MCU destination register.
- `mc_wD` in 32: MCU result data.
- `iss_valid` in 1: MCU op issued this cycle.
- `iss_rd` in 5: destination of the issued MCU op.
- `q_rs1`, `q_rs2`, `q_rd` in 5 each: decode-stage operands to check.
- `hz_stall` out 1: decode must stall (operand or destination busy).
- `wb_stall` out 1: pipeline freeze request (fairness). Tied 0 without `RF_WR_FAIR_EN`.
- `rf_we` out 1, `rf_wR` out 5, `rf_wD` out 32: RF write port.

## Operation
- WB is active when `wb_we && wb_wR != 0`. WB active: `rf_we=1`, `rf_wR/rf_wD` = WB values, and the FIFO does not pop.
- WB idle and FIFO non-empty: head drives the port and pops at the edge. Head with `wR==0` pops with `rf_we=0`.
- Otherwise `rf_we=0`, `rf_wR=0`, `rf_wD=0`.
- Port mux is combinational from WB inputs and FIFO head.
- Push on `mc_valid && mc_ready`. Push and pop in the same cycle are both honoured; count is unchanged. No cut-through: a pushed entry is written to the RF no earlier than the next cycle.
- Scoreboard `busy[31:1]`:
  - Set on `iss_valid && iss_rd != 0`.
  - Cleared when an MCU entry for that register is popped.
  - When set and clear hit the same register in the same cycle, set wins.
  - `busy[0]` is constantly 0.
- `hz_stall = busy[q_rs1] | busy[q_rs2] | busy[q_rd]` (combinational; x0 never busy).
- WB write to a busy register is a decode bug; it is ignored by the scoreboard (busy is unchanged).

## Timing
- Reset (`rst_n=0`, asynchronous):
  - FIFO empty, pointers and count zero.
  - `busy` all zero, starvation counter zero.
  - Outputs: `mc_ready=1`, `hz_stall=0`, `wb_stall=0`, `rf_we=0`, `rf_wR=0`, `rf_wD=0`.
- Reset mid-operation discards buffered results and all busy bits.
- Latency from MCU accept to RF write: minimum 1 cycle (edge after push), plus one cycle per WB-active cycle and per older entry.
- `busy` clears at the same edge the RF captures the data, so a decode query in the following cycle sees no stall and reads the new value.
- Full: `mc_ready=0`. MCU must hold `mc_valid`, `mc_wR` and `mc_wD` stable until accepted.
- Pointer wrap-around is modulo `DEPTH`. Count width is `$clog2(DEPTH)+1`.

## Configuration
- `RF_WR_FAIR_EN` defined:
  - A starvation counter increments each cycle with the FIFO full and WB active, and resets to 0 otherwise.
  - When it reaches `STARVE_LIM`, `wb_stall` is asserted (registered) for exactly one cycle and the counter clears.
  - The pipeline drops `wb_we` that cycle, so the FIFO drains one entry.
- `RF_WR_FAIR_EN` undefined: no counter, `wb_stall` is constant 0, and WB may starve the MCU indefinitely.

## Test plan
- Reset, then `iss_valid` with rd=5, then MCU result (rd=5, 0xDEADBEEF) with WB idle → `rf_we=1`, `rf_wR=5` one cycle after accept. `hz_stall` for `q_rs1=5` drops the cycle after the write.
- WB writing every cycle while the MCU pushes 4 results (DEPTH=4) → `mc_ready=0` after the 4th. When WB goes idle, entries are written in FIFO order on consecutive cycles.
- `iss_rd=7` set and a pop of an rd=7 entry in the same cycle → `busy[7]` stays 1.
- MCU result for x0 and WB write to x0 → `rf_we=0` on both; the x0 entry is popped; `hz_stall` never asserts for x0 queries.
- Assert `rst_n=0` with 3 entries buffered and busy bits set → all outputs return to reset values immediately, and `mc_ready=1`.
- With `RF_WR_FAIR_EN`, STARVE_LIM=8: FIFO full and WB active for 8 cycles → one-cycle `wb_stall`, then one FIFO entry is written. Without the macro, `wb_stall` stays 0 throughout.
